// File: rtl/stream_mux_pkg.sv
// Shared types for the 2:1 packet stream merger: lock FSM encoding and source index width.
package stream_mux_pkg;

  localparam int SRC_W = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  function automatic logic [SRC_W-1:0] other_src(input logic [SRC_W-1:0] s);
    return ~s;
  endfunction

endpackage

// File: rtl/stream_mux_2to1_rr_arb2.sv
// Two-request round-robin arbiter. Grant is combinational; a hold input pins the grant
// to a locked source, and the priority pointer moves on an update pulse.
module rr_arb2
  import stream_mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_req,
  input  logic             i_hold,
  input  logic [SRC_W-1:0] i_hold_src,
  input  logic             i_upd,
  input  logic [SRC_W-1:0] i_upd_src,
  output logic             o_gnt_vld,
  output logic [SRC_W-1:0] o_gnt
);

  logic [SRC_W-1:0] r_prio;

  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt     = r_prio;
    if (i_hold) begin
      o_gnt_vld = 1'b1;
      o_gnt     = i_hold_src;
    end else begin
      case (i_req)
        2'b01: begin
          o_gnt_vld = 1'b1;
          o_gnt     = 1'b0;
        end
        2'b10: begin
          o_gnt_vld = 1'b1;
          o_gnt     = 1'b1;
        end
        2'b11: begin
          o_gnt_vld = 1'b1;
          o_gnt     = r_prio;
        end
        default: begin
          o_gnt_vld = 1'b0;
          o_gnt     = r_prio;
        end
      endcase
    end
  end

  // The source that just finished a packet drops to the lower priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= '0;
    end else if (i_upd) begin
      r_prio <= other_src(i_upd_src);
    end
  end

endmodule

// File: rtl/stream_mux_2to1.sv
// Merges two valid/ready packet streams into one registered output stream with
// packet-granular round-robin arbitration, 1-cycle latency and full throughput.
module stream_mux_2to1
  import stream_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);

  state_e            r_state_p0;
  state_e            w_state_nxt;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_last_p1;
  logic [SRC_W-1:0]  r_src_p1;

  logic              w_slot_free;
  logic              w_hold;
  logic [SRC_W-1:0]  w_hold_src;
  logic              w_gnt_vld;
  logic [SRC_W-1:0]  w_gnt;
  logic              w_acc;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;

  assign w_slot_free = !r_vld_p1 || out_ready;
  assign w_hold      = (r_state_p0 != IDLE);
  assign w_hold_src  = (r_state_p0 == LOCK1);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      ({in1_valid, in0_valid}),
    .i_hold     (w_hold),
    .i_hold_src (w_hold_src),
    .i_upd      (w_acc && w_sel_last),
    .i_upd_src  (w_gnt),
    .o_gnt_vld  (w_gnt_vld),
    .o_gnt      (w_gnt)
  );

  // While locked the grant is fixed, so ready does not wait on the locked source's valid.
  assign in0_ready = w_gnt_vld && (w_gnt == 1'b0) && w_slot_free && !rst;
  assign in1_ready = w_gnt_vld && (w_gnt == 1'b1) && w_slot_free && !rst;

  assign w_acc      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign w_sel_data = w_gnt ? in1_data : in0_data;
  assign w_sel_last = w_gnt ? in1_last : in0_last;

  always_comb begin
    w_state_nxt = r_state_p0;
    if (w_acc) begin
      if (w_sel_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = w_gnt ? LOCK1 : LOCK0;
      end
    end
  end

  // p0: packet lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_p0 <= IDLE;
    end else begin
      r_state_p0 <= w_state_nxt;
    end
  end

  // p1: registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_last_p1 <= 1'b0;
      r_src_p1  <= '0;
    end else if (w_acc) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_sel_data;
      r_last_p1 <= w_sel_last;
      r_src_p1  <= w_gnt;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_last  = r_last_p1;
  assign out_src   = r_src_p1;

endmodule
